// File: rtl/y86_pkg.sv
// Shared Y86 encodings used by the PIPE execute stage: icodes, ALU/condition
// function codes, stat codes, and the condition evaluator.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    // cc is packed {ZF, SF, OF}
    function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
        logic zf, sf, of;
        logic res;
        {zf, sf, of} = cc;
        case (ifun)
            C_YES:   res = 1'b1;
            C_LE:    res = (sf ^ of) | zf;
            C_L:     res = sf ^ of;
            C_E:     res = zf;
            C_NE:    res = !zf;
            C_GE:    res = !(sf ^ of);
            C_G:     res = !(sf ^ of) & !zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_flags.sv
// Combinational Y86 ALU with ZF/SF/OF generation. Undefined function codes
// yield a zero result with OF clear.
module alu_flags
    import y86_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [3:0]        fun,
    output logic [DATA_W-1:0] val_e,
    output logic              zf,
    output logic              sf,
    output logic              of
);

    logic sign_a, sign_b, sign_r;

    always_comb begin
        val_e = '0;
        case (fun)
            ALU_ADD: val_e = alu_b + alu_a;
            ALU_SUB: val_e = alu_b - alu_a;
            ALU_AND: val_e = alu_b & alu_a;
            ALU_XOR: val_e = alu_b ^ alu_a;
            default: val_e = '0;
        endcase
    end

    assign sign_a = alu_a[DATA_W-1];
    assign sign_b = alu_b[DATA_W-1];
    assign sign_r = val_e[DATA_W-1];

    always_comb begin
        of = 1'b0;
        case (fun)
            ALU_ADD: of = (sign_a == sign_b) && (sign_r != sign_a);
            ALU_SUB: of = (sign_a != sign_b) && (sign_r != sign_b);
            default: of = 1'b0;
        endcase
    end

    assign zf = (val_e == '0);
    assign sf = sign_r;

endmodule

// File: rtl/execute_stage_pipe.sv
// PIPE Y86 execute stage: operand selection, ALU, condition codes, cmov/jXX
// condition, and the M pipeline register with stall/bubble control.
module execute_stage_pipe
    import y86_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int REG_ID_W   = 4,
    parameter int WORD_BYTES = DATA_W / 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          E_stat,
    input  logic [3:0]          E_icode,
    input  logic [3:0]          E_ifun,
    input  logic [DATA_W-1:0]   E_valA,
    input  logic [DATA_W-1:0]   E_valB,
    input  logic [DATA_W-1:0]   E_valC,
    input  logic [REG_ID_W-1:0] E_dstE,
    input  logic [REG_ID_W-1:0] E_dstM,
    input  logic [2:0]          m_stat,
    input  logic [2:0]          W_stat,
    input  logic                M_stall,
    input  logic                M_bubble,
    output logic [DATA_W-1:0]   e_valE,
    output logic [REG_ID_W-1:0] e_dstE,
    output logic                e_cnd,
    output logic [2:0]          M_stat,
    output logic [3:0]          M_icode,
    output logic                M_cnd,
    output logic [DATA_W-1:0]   M_valE,
    output logic [DATA_W-1:0]   M_valA,
    output logic [REG_ID_W-1:0] M_dstE,
    output logic [REG_ID_W-1:0] M_dstM,
    output logic [2:0]          cc
);

    localparam logic [REG_ID_W-1:0] REG_NONE = '1;
    localparam logic [DATA_W-1:0]   STK_ADJ  = DATA_W'(WORD_BYTES);

    logic [DATA_W-1:0] alu_a, alu_b;
    logic [3:0]        alu_fun;
    logic              alu_zf, alu_sf, alu_of;
    logic              set_cc;
    logic              cnd_raw;

    logic [2:0]          cc_d, cc_q;
    logic [2:0]          mreg_stat_d, mreg_stat_q;
    logic [3:0]          mreg_icode_d, mreg_icode_q;
    logic                mreg_cnd_d, mreg_cnd_q;
    logic [DATA_W-1:0]   mreg_vale_d, mreg_vale_q;
    logic [DATA_W-1:0]   mreg_vala_d, mreg_vala_q;
    logic [REG_ID_W-1:0] mreg_dste_d, mreg_dste_q;
    logic [REG_ID_W-1:0] mreg_dstm_d, mreg_dstm_q;

    always_comb begin
        alu_a = '0;
        case (E_icode)
            IOPQ, IRRMOVQ:           alu_a = E_valA;
            IIRMOVQ, IRMMOVQ,
            IMRMOVQ:                 alu_a = E_valC;
            ICALL, IPUSHQ:           alu_a = -STK_ADJ;
            IRET, IPOPQ:             alu_a = STK_ADJ;
            default:                 alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (E_icode)
            IOPQ, IRMMOVQ, IMRMOVQ,
            ICALL, IPUSHQ, IRET,
            IPOPQ:                   alu_b = E_valB;
            default:                 alu_b = '0;
        endcase
    end

    assign alu_fun = (E_icode == IOPQ) ? E_ifun : ALU_ADD;

    alu_flags #(.DATA_W(DATA_W)) u_alu (
        .alu_a (alu_a),
        .alu_b (alu_b),
        .fun   (alu_fun),
        .val_e (e_valE),
        .zf    (alu_zf),
        .sf    (alu_sf),
        .of    (alu_of)
    );

    // Condition uses the flags from older instructions, not this one's ALU result
    assign cnd_raw = cond_eval(E_ifun, cc_q);
    assign e_cnd   = ((E_icode == IJXX) || (E_icode == IRRMOVQ)) ? cnd_raw : 1'b0;
    assign e_dstE  = ((E_icode == IRRMOVQ) && !e_cnd) ? REG_NONE : E_dstE;

    // A faulting instruction ahead in M or W must not see CC side effects from this one
    assign set_cc = (E_icode == IOPQ) && (E_ifun <= ALU_XOR) && (E_stat == SAOK) &&
                    ((m_stat == SAOK) || (m_stat == SBUB)) &&
                    ((W_stat == SAOK) || (W_stat == SBUB)) && !M_stall;

    always_comb begin
        cc_d = cc_q;
        if (set_cc) cc_d = {alu_zf, alu_sf, alu_of};
    end

    always_comb begin
        mreg_stat_d  = mreg_stat_q;
        mreg_icode_d = mreg_icode_q;
        mreg_cnd_d   = mreg_cnd_q;
        mreg_vale_d  = mreg_vale_q;
        mreg_vala_d  = mreg_vala_q;
        mreg_dste_d  = mreg_dste_q;
        mreg_dstm_d  = mreg_dstm_q;
        if (M_stall) begin
            mreg_stat_d = mreg_stat_q;
        end else if (M_bubble) begin
            mreg_stat_d  = SBUB;
            mreg_icode_d = INOP;
            mreg_cnd_d   = 1'b0;
            mreg_vale_d  = '0;
            mreg_vala_d  = '0;
            mreg_dste_d  = REG_NONE;
            mreg_dstm_d  = REG_NONE;
        end else begin
            mreg_stat_d  = E_stat;
            mreg_icode_d = E_icode;
            mreg_cnd_d   = e_cnd;
            mreg_vale_d  = e_valE;
            mreg_vala_d  = E_valA;
            mreg_dste_d  = e_dstE;
            mreg_dstm_d  = E_dstM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc_q         <= 3'b100;
            mreg_stat_q  <= SBUB;
            mreg_icode_q <= INOP;
            mreg_cnd_q   <= 1'b0;
            mreg_vale_q  <= '0;
            mreg_vala_q  <= '0;
            mreg_dste_q  <= REG_NONE;
            mreg_dstm_q  <= REG_NONE;
        end else begin
            cc_q         <= cc_d;
            mreg_stat_q  <= mreg_stat_d;
            mreg_icode_q <= mreg_icode_d;
            mreg_cnd_q   <= mreg_cnd_d;
            mreg_vale_q  <= mreg_vale_d;
            mreg_vala_q  <= mreg_vala_d;
            mreg_dste_q  <= mreg_dste_d;
            mreg_dstm_q  <= mreg_dstm_d;
        end
    end

    assign cc      = cc_q;
    assign M_stat  = mreg_stat_q;
    assign M_icode = mreg_icode_q;
    assign M_cnd   = mreg_cnd_q;
    assign M_valE  = mreg_vale_q;
    assign M_valA  = mreg_vala_q;
    assign M_dstE  = mreg_dste_q;
    assign M_dstM  = mreg_dstm_q;

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Self-checking bench for execute_stage_pipe: table-driven vectors through a
// scoreboard queue, plus hand-written reset/stall/bubble sequences.
module tb_execute_stage_pipe;
    import y86_pkg::*;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    E_stat;
    logic [3:0]    E_icode, E_ifun;
    logic [DW-1:0] E_valA, E_valB, E_valC;
    logic [3:0]    E_dstE, E_dstM;
    logic [2:0]    m_stat, W_stat;
    logic          M_stall, M_bubble;
    logic [DW-1:0] e_valE;
    logic [3:0]    e_dstE;
    logic          e_cnd;
    logic [2:0]    M_stat;
    logic [3:0]    M_icode;
    logic          M_cnd;
    logic [DW-1:0] M_valE, M_valA;
    logic [3:0]    M_dstE, M_dstM;
    logic [2:0]    cc;

    execute_stage_pipe #(.DATA_W(DW), .REG_ID_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .m_stat(m_stat), .W_stat(W_stat),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .cc(cc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [3:0]    icode;
        logic [3:0]    ifun;
        logic [DW-1:0] va;
        logic [DW-1:0] vb;
        logic [DW-1:0] vc;
        logic [3:0]    dste;
        logic [2:0]    mst;
        logic [2:0]    wst;
        logic [DW-1:0] x_vale;
        logic          x_cnd;
        logic [3:0]    x_dste;
        logic [2:0]    x_cc;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic vec_t mk(string nm, logic [3:0] ic, logic [3:0] fn,
                                logic [DW-1:0] va, logic [DW-1:0] vb, logic [DW-1:0] vc,
                                logic [3:0] de, logic [2:0] ms, logic [2:0] ws,
                                logic [DW-1:0] xv, logic xc, logic [3:0] xd, logic [2:0] xcc);
        vec_t v;
        v.name = nm; v.icode = ic; v.ifun = fn; v.va = va; v.vb = vb; v.vc = vc;
        v.dste = de; v.mst = ms; v.wst = ws;
        v.x_vale = xv; v.x_cnd = xc; v.x_dste = xd; v.x_cc = xcc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [DW-1:0] va,
                         input logic [DW-1:0] vb, input logic [DW-1:0] vc, input logic [3:0] de,
                         input logic [2:0] ms, input logic [2:0] ws, input logic st, input logic bu);
        E_stat = SAOK; E_icode = ic; E_ifun = fn;
        E_valA = va; E_valB = vb; E_valC = vc;
        E_dstE = de; E_dstM = 4'hF;
        m_stat = ms; W_stat = ws; M_stall = st; M_bubble = bu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        tbl.push_back(mk("add_ovf", IOPQ, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'd2, SAOK, SAOK, 64'h8000_0000_0000_0000, 1'b0, 4'd2, 3'b011));
        tbl.push_back(mk("sub_zero", IOPQ, ALU_SUB, 64'd5, 64'd5, 64'd0, 4'd2, SAOK, SAOK, 64'd0, 1'b0, 4'd2, 3'b100));
        tbl.push_back(mk("je", IJXX, C_E, 64'd0, 64'd0, 64'h40, 4'hF, SAOK, SAOK, 64'd0, 1'b1, 4'hF, 3'b100));
        tbl.push_back(mk("jne", IJXX, C_NE, 64'd0, 64'd0, 64'h40, 4'hF, SAOK, SAOK, 64'd0, 1'b0, 4'hF, 3'b100));
        tbl.push_back(mk("jle", IJXX, C_LE, 64'd0, 64'd0, 64'h40, 4'hF, SAOK, SAOK, 64'd0, 1'b1, 4'hF, 3'b100));
        tbl.push_back(mk("add_small", IOPQ, ALU_ADD, 64'd1, 64'd1, 64'd0, 4'd4, SAOK, SAOK, 64'd2, 1'b0, 4'd4, 3'b000));
        tbl.push_back(mk("cmovl_no", IRRMOVQ, C_L, 64'd9, 64'd0, 64'd0, 4'd3, SAOK, SAOK, 64'd9, 1'b0, 4'hF, 3'b000));
        tbl.push_back(mk("add_neg", IOPQ, ALU_ADD, 64'd0, 64'h8000_0000_0000_0000, 64'd0, 4'd4, SAOK, SAOK, 64'h8000_0000_0000_0000, 1'b0, 4'd4, 3'b010));
        tbl.push_back(mk("cmovl_yes", IRRMOVQ, C_L, 64'd9, 64'd0, 64'd0, 4'd3, SAOK, SAOK, 64'd9, 1'b1, 4'd3, 3'b010));
        tbl.push_back(mk("sub_madr", IOPQ, ALU_SUB, 64'd5, 64'd5, 64'd0, 4'd5, SADR, SAOK, 64'd0, 1'b0, 4'd5, 3'b010));
        tbl.push_back(mk("sub_wins", IOPQ, ALU_SUB, 64'd5, 64'd5, 64'd0, 4'd5, SAOK, SINS, 64'd0, 1'b0, 4'd5, 3'b010));
        tbl.push_back(mk("opq_bad", IOPQ, 4'd5, 64'd3, 64'd4, 64'd0, 4'd6, SAOK, SAOK, 64'd0, 1'b0, 4'd6, 3'b010));
        tbl.push_back(mk("irmovq", IIRMOVQ, 4'd0, 64'd7, 64'd8, 64'h1234, 4'd7, SAOK, SAOK, 64'h1234, 1'b0, 4'd7, 3'b010));
        tbl.push_back(mk("rmmovq", IRMMOVQ, 4'd0, 64'd7, 64'h20, 64'h10, 4'hF, SAOK, SAOK, 64'h30, 1'b0, 4'hF, 3'b010));
        tbl.push_back(mk("pushq", IPUSHQ, 4'd0, 64'd1, 64'h100, 64'd0, 4'd4, SAOK, SAOK, 64'hF8, 1'b0, 4'd4, 3'b010));
        tbl.push_back(mk("popq", IPOPQ, 4'd0, 64'd1, 64'h100, 64'd0, 4'd4, SAOK, SAOK, 64'h108, 1'b0, 4'd4, 3'b010));
        tbl.push_back(mk("and", IOPQ, ALU_AND, 64'hF0F0, 64'hFF00, 64'd0, 4'd1, SAOK, SAOK, 64'hF000, 1'b0, 4'd1, 3'b000));
        tbl.push_back(mk("xor", IOPQ, ALU_XOR, 64'hAA, 64'hAA, 64'd0, 4'd1, SAOK, SAOK, 64'd0, 1'b0, 4'd1, 3'b100));
        tbl.push_back(mk("sub_neg", IOPQ, ALU_SUB, 64'd1, 64'd0, 64'd0, 4'd1, SAOK, SAOK, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd1, 3'b010));

        // reset held two cycles with a live instruction on the E inputs
        rst_n = 1'b0;
        drive(IOPQ, ALU_ADD, 64'd1, 64'd1, 64'd0, 4'd2, SAOK, SAOK, 1'b0, 1'b0);
        repeat (2) tick();
        chk("rst_icode", 64'(M_icode), 64'(INOP));
        chk("rst_stat", 64'(M_stat), 64'(SBUB));
        chk("rst_dstE", 64'(M_dstE), 64'hF);
        chk("rst_dstM", 64'(M_dstM), 64'hF);
        chk("rst_valE", M_valE, 64'd0);
        chk("rst_cc", 64'(cc), 64'b100);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            v = tbl[i];
            drive(v.icode, v.ifun, v.va, v.vb, v.vc, v.dste, v.mst, v.wst, 1'b0, 1'b0);
            #1;
            chk({v.name, "_e_valE"}, e_valE, v.x_vale);
            chk({v.name, "_e_dstE"}, 64'(e_dstE), 64'(v.x_dste));
            chk({v.name, "_e_cnd"}, 64'(e_cnd), 64'(v.x_cnd));
            sb.push_back(v);
            tick();
            v = sb.pop_front();
            chk({v.name, "_M_valE"}, M_valE, v.x_vale);
            chk({v.name, "_M_valA"}, M_valA, v.va);
            chk({v.name, "_M_dstE"}, 64'(M_dstE), 64'(v.x_dste));
            chk({v.name, "_M_cnd"}, 64'(M_cnd), 64'(v.x_cnd));
            chk({v.name, "_M_icode"}, 64'(M_icode), 64'(v.icode));
            chk({v.name, "_M_stat"}, 64'(M_stat), 64'(SAOK));
            chk({v.name, "_cc"}, 64'(cc), 64'(v.x_cc));
        end

        // stall holds M and blocks the CC update
        drive(IOPQ, ALU_ADD, 64'd1, 64'd1, 64'd0, 4'd2, SAOK, SAOK, 1'b1, 1'b0);
        tick();
        chk("stall_valE", M_valE, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("stall_dstE", 64'(M_dstE), 64'd1);
        chk("stall_cc", 64'(cc), 64'b010);

        drive(IOPQ, ALU_ADD, 64'd1, 64'd1, 64'd0, 4'd2, SAOK, SAOK, 1'b1, 1'b1);
        tick();
        chk("stallbub_valE", M_valE, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("stallbub_icode", 64'(M_icode), 64'(IOPQ));

        // bubble alone inserts a NOP but the OPq in E still sets CC
        drive(IOPQ, ALU_ADD, 64'd1, 64'd1, 64'd0, 4'd2, SAOK, SAOK, 1'b0, 1'b1);
        tick();
        chk("bub_icode", 64'(M_icode), 64'(INOP));
        chk("bub_stat", 64'(M_stat), 64'(SBUB));
        chk("bub_valE", M_valE, 64'd0);
        chk("bub_dstE", 64'(M_dstE), 64'hF);
        chk("bub_cc", 64'(cc), 64'b000);

        drive(IIRMOVQ, 4'd0, 64'd0, 64'd0, 64'h77, 4'd8, SAOK, SAOK, 1'b0, 1'b0);
        tick();
        chk("reload_valE", M_valE, 64'h77);

        // reset wins over stall
        rst_n = 1'b0;
        drive(IOPQ, ALU_ADD, 64'd1, 64'd1, 64'd0, 4'd2, SAOK, SAOK, 1'b1, 1'b0);
        tick();
        chk("rststall_icode", 64'(M_icode), 64'(INOP));
        chk("rststall_valE", M_valE, 64'd0);
        chk("rststall_dstE", 64'(M_dstE), 64'hF);
        chk("rststall_cc", 64'(cc), 64'b100);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
